line_hit_ctrl: RTL and testbench
================================

Name: line_hit_ctrl

Overview:
- Game-control stage directly downstream of the horizontal-line renderers. It consumes their combined line pixel and the cube pixel, and detects collisions per frame.
- It drives the line stages' control inputs: load_counter, start_machine, stop (run) and flash.
- It tracks lives and game-over state, and sits between the pixel-generation stages and the VGA/score logic.

Parameters:
- HIT_THRESH, 4: overlapping pixels in one frame needed to register a hit.
- OVL_W, 8: width of the per-frame overlap counter. The counter saturates.
- FLASH_FRAMES, 15: frames per flash half-period.
- FLASH_BLINKS, 3: full blink periods shown after a hit.
- LIVES, 3: lives at game start. Must be in the range 1..7.

Ports:
- clk  in  1  system pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame  in  1  frame tick, asynchronous to logic. Synchronised internally; its rising edge marks end of frame.
- start  in  1  debounced start button, level.
- line_px  in  1  OR of all h_line outputs for the current pixel.
- cube_px  in  1  cube pixel for the current pixel.
- load_counter  out  1  loads the line motion counters.
- start_machine  out  1  enables the line motion FSMs.
- run  out  1  drives the line stages' stop input. 1 = lines move and are drawn solid.
- flash  out  1  blink enable for the line stages.
- lives  out  3  remaining lives.
- game_over  out  1  high while in the OVER state.

Behaviour:
Reset (asynchronous, reset_n=0) values:
- state=IDLE, lives=LIVES, overlap count=0, frame divider=0.
- load_counter=1, start_machine=0, run=0, flash=1, game_over=0.

Frame edge:
- frame passes through a 2-FF synchroniser, then a rising-edge detector.
- fe is a 1-clk pulse, 3 clk after the frame rises.

Start edge:
- se is a 1-clk pulse on the start 0->1 transition, taken from a registered copy of start.

Overlap counter:
- Increments on every clk where line_px & cube_px, and saturates at 2^OVL_W-1.
- On a fe cycle, the counter value (including that cycle's pixel) is evaluated first, then cleared to 0.
- It counts only in PLAY. It is held at 0 in all other states.

FSM states:
- IDLE
  - Outputs: load_counter=1, flash=1, run=0.
  - Transition: se -> LOAD.
- LOAD
  - Outputs: load_counter=1.
  - Transition: on the next fe -> PLAY, so the line counters see at least one frame of load.
- PLAY
  - Outputs: run=1, start_machine=1, load_counter=0, flash=1.
  - Transition: on fe, if count >= HIT_THRESH, then lives decrements.
    - If the new lives value is 0 -> OVER.
    - Otherwise -> HIT.
- HIT
  - Outputs: run=0, start_machine=0.
  - Flash: a divider counts fe. flash toggles every FLASH_FRAMES fe pulses, starting at 0 on entry.
  - Transition: after 2*FLASH_BLINKS toggles (flash back to 1) -> PLAY, with the divider cleared.
- OVER
  - Outputs: game_over=1, run=0, start_machine=0, flash=1 (lines shown solid and frozen).
  - Transition: se -> LOAD, with lives=LIVES.

Output timing:
- All outputs are registered and change 1 clk after the deciding fe or se.

Boundary cases:
- Simultaneous fe and se: se is ignored in every state except IDLE and OVER.
  - In those two states se takes effect, and the fe is consumed by the transition.
- An fe arriving in the same cycle as an overlap pixel counts that pixel.
- The lives counter never underflows. The 0 check happens on the decremented value.
- start held high produces exactly one se.
- reset_n asserted mid-HIT or mid-PLAY returns to reset values immediately, regardless of clk.

Decomposition:
- Shared package: the state encoding (IDLE, LOAD, PLAY, HIT, OVER), plus default constants for HIT_THRESH, FLASH_FRAMES and LIVES.
- One natural sub-module, edge_sync: 2-FF synchroniser plus rising-edge pulse.
  - Instantiated twice: once for frame (synchronised) and once for start (edge only).
- Everything else stays in line_hit_ctrl.

Test Plan:
- Reset and start: hold reset_n=0, then release.
  - Expect IDLE outputs: load_counter=1, run=0, flash=1, lives=3.
  - Pulse start -> LOAD. After the next fe, expect PLAY with run=1, start_machine=1, load_counter=0.
- Threshold boundary: in PLAY, drive 3 overlap pixels in a frame -> no hit.
  - Next frame drive 4 -> lives=2, state HIT, run=0 one clk after fe.
- Blink timing: in HIT with FLASH_FRAMES=15 and FLASH_BLINKS=3.
  - flash toggles at fe #15, 30, …, 90.
  - After 6 toggles, state PLAY with run=1 and flash=1.
- Game over: cause 3 hits -> lives=0, game_over=1, run=0, flash=1.
  - Further overlap does nothing.
  - start pulse -> LOAD with lives=3.
- Saturation and edges:
  - 300 overlap pixels in one frame -> counter holds at 255, and exactly one hit is counted.
  - fe and an overlap pixel in the same cycle -> the pixel counts toward that frame.
- Asynchronous reset mid-HIT: assert reset_n=0 between clk edges -> outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/line_hit_ctrl_pkg.sv
// line_hit_ctrl_pkg: game-control state encoding and default tuning constants
package line_hit_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, HIT, OVER} state_e;
  localparam int HIT_THRESH_DEF   = 4;
  localparam int OVL_W_DEF        = 8;
  localparam int FLASH_FRAMES_DEF = 15;
  localparam int FLASH_BLINKS_DEF = 3;
  localparam int LIVES_DEF        = 3;
endpackage

// File: rtl/line_hit_ctrl_edge_sync.sv
// line_hit_ctrl_edge_sync: optional 2-FF synchroniser followed by a registered rising-edge pulse
module line_hit_ctrl_edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic pulse_o
);
  logic [1:0] sync_q;
  logic       prev_q, pulse_q, d;
  assign d       = SYNC ? sync_q[1] : d_i;
  assign pulse_o = pulse_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      prev_q  <= d;
      pulse_q <= d & ~prev_q;
    end
  end
endmodule

// File: rtl/line_hit_ctrl.sv
// line_hit_ctrl: per-frame collision detection, lives/game-over tracking and line-stage control
module line_hit_ctrl
  import line_hit_ctrl_pkg::*;
#(
  parameter int HIT_THRESH   = HIT_THRESH_DEF,
  parameter int OVL_W        = OVL_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int FLASH_BLINKS = FLASH_BLINKS_DEF,
  parameter int LIVES        = LIVES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame,
  input  logic       start,
  input  logic       line_px,
  input  logic       cube_px,
  output logic       load_counter,
  output logic       start_machine,
  output logic       run,
  output logic       flash,
  output logic [2:0] lives,
  output logic       game_over
);
  localparam int DW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(2 * FLASH_BLINKS + 1);
  localparam logic [OVL_W-1:0] OVL_MAX = '1;

  state_e           state_q, state_d;
  logic [OVL_W-1:0] ovl_q, ovl_d, ovl_inc;
  logic [DW-1:0]    div_q, div_d;
  logic [TW-1:0]    tog_q, tog_d;
  logic [2:0]       lives_q, lives_d;
  logic             flash_q, flash_d, fe, se, hit_now, wrap;
  logic             load_q, sm_q, run_q, go_q;

  line_hit_ctrl_edge_sync #(.SYNC(1'b1)) u_frame (
    .clk(clk), .reset_n(reset_n), .d_i(frame), .pulse_o(fe)
  );
  line_hit_ctrl_edge_sync #(.SYNC(1'b0)) u_start (
    .clk(clk), .reset_n(reset_n), .d_i(start), .pulse_o(se)
  );

  assign load_counter  = load_q;
  assign start_machine = sm_q;
  assign run           = run_q;
  assign flash         = flash_q;
  assign lives         = lives_q;
  assign game_over     = go_q;

  always_comb begin
    ovl_inc = (ovl_q == OVL_MAX) ? ovl_q : ovl_q + OVL_W'(line_px & cube_px);
    hit_now = 32'(ovl_inc) >= HIT_THRESH;
    wrap    = fe && (div_q == DW'(FLASH_FRAMES - 1));
    state_d = state_q;
    ovl_d   = '0;
    div_d   = '0;
    tog_d   = '0;
    lives_d = lives_q;
    flash_d = 1'b1;
    case (state_q)
      IDLE: state_d = se ? LOAD : IDLE;
      LOAD: state_d = fe ? PLAY : LOAD;
      PLAY: begin
        ovl_d = fe ? '0 : ovl_inc;
        if (fe && hit_now && lives_q != 3'd0) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? OVER : HIT;
          flash_d = lives_q == 3'd1;
        end
      end
      HIT: begin
        div_d   = wrap ? '0 : div_q + DW'(fe);
        tog_d   = tog_q + TW'(wrap);
        flash_d = flash_q ^ wrap;
        // last toggle of the blink sequence hands control back to play
        if (wrap && tog_q == TW'(2 * FLASH_BLINKS - 1)) begin
          state_d = PLAY;
          tog_d   = '0;
          flash_d = 1'b1;
        end
      end
      OVER: if (se) begin
        state_d = LOAD;
        lives_d = 3'(LIVES);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ovl_q   <= '0;
      div_q   <= '0;
      tog_q   <= '0;
      lives_q <= 3'(LIVES);
      flash_q <= 1'b1;
      load_q  <= 1'b1;
      sm_q    <= 1'b0;
      run_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ovl_q   <= ovl_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      lives_q <= lives_d;
      flash_q <= flash_d;
      load_q  <= (state_d == IDLE) || (state_d == LOAD);
      sm_q    <= state_d == PLAY;
      run_q   <= state_d == PLAY;
      go_q    <= state_d == OVER;
    end
  end
endmodule

// File: tb/tb_line_hit_ctrl.sv
// tb_line_hit_ctrl: directed and randomized checks of line_hit_ctrl against a frame-level game model
module tb_line_hit_ctrl;
  localparam int FF = 15, FB = 3, TH = 4, NL = 3, OMAX = 255;
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_HIT = 3, M_OVER = 4;

  logic clk = 1'b0, reset_n = 1'b0, frame = 1'b0, start = 1'b0, line_px = 1'b0, cube_px = 1'b0;
  logic load_counter, start_machine, run, flash, game_over;
  logic [2:0] lives;
  int tests = 0, fails = 0;
  bit started = 1'b0;
  int mode, m_lives, m_cnt, m_n;
  bit [3:0] fh;
  bit [1:0] sh;
  bit m_fe, m_se;

  always #5 clk = ~clk;

  line_hit_ctrl #(
    .HIT_THRESH(TH), .OVL_W(8), .FLASH_FRAMES(FF), .FLASH_BLINKS(FB), .LIVES(NL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame(frame), .start(start),
    .line_px(line_px), .cube_px(cube_px), .load_counter(load_counter),
    .start_machine(start_machine), .run(run), .flash(flash),
    .lives(lives), .game_over(game_over)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // frame rise is seen 3 clk later, start rise 1 clk later; the game then reacts on that edge
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mode = M_IDLE; m_lives = NL; m_cnt = 0; m_n = 0; fh = '0; sh = '0;
    end else begin
      m_fe = fh[2] & ~fh[3];
      m_se = sh[0] & ~sh[1];
      fh = {fh[2:0], frame};
      sh = {sh[0], start};
      case (mode)
        M_IDLE: if (m_se) mode = M_LOAD;
        M_LOAD: if (m_fe) mode = M_PLAY;
        M_PLAY: begin
          if (line_px && cube_px && m_cnt < OMAX) m_cnt++;
          if (m_fe) begin
            if (m_cnt >= TH) begin
              m_lives--;
              mode = (m_lives == 0) ? M_OVER : M_HIT;
              m_n = 0;
            end
            m_cnt = 0;
          end
        end
        M_HIT: if (m_fe) begin
          m_n++;
          if (m_n == 2 * FB * FF) mode = M_PLAY;
        end
        default: if (m_se) begin
          mode = M_LOAD;
          m_lives = NL;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("load_counter", load_counter, mode == M_IDLE || mode == M_LOAD);
      chk("start_machine", start_machine, mode == M_PLAY);
      chk("run", run, mode == M_PLAY);
      chk("flash", flash, mode == M_HIT ? ((m_n / FF) % 2 == 1) : 1'b1);
      chk("lives", lives, m_lives);
      chk("game_over", game_over, mode == M_OVER);
      chk("ovl_count", dut.ovl_q, m_cnt);
    end
  end

  task automatic pixels(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line_px = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      cube_px = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    @(negedge clk);
    line_px = 1'b0; cube_px = 1'b0;
  endtask

  // px lands on exactly the cycle the synchronised frame pulse is high
  task automatic frame_tick(input bit px, input int hi);
    @(negedge clk);
    frame = 1'b1; line_px = 1'b0; cube_px = 1'b0;
    repeat (3) @(negedge clk);
    line_px = px; cube_px = px;
    @(negedge clk);
    line_px = 1'b0; cube_px = 1'b0;
    repeat (hi) @(negedge clk);
    frame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_pulse(input int len);
    @(negedge clk);
    start = 1'b1;
    repeat (len) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic blink();
    for (int n = 1; n <= 2 * FB * FF; n++) begin
      frame_tick(1'b0, 0);
      if (n == 14) chk("blink14_flash", flash, 0);
      if (n == 15) chk("blink15_flash", flash, 1);
      if (n == 89) chk("blink89_run", run, 0);
      if (n == 90) begin
        chk("blink90_run", run, 1);
        chk("blink90_flash", flash, 1);
      end
    end
  endtask

  task automatic areset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_run", run, 0);
    chk("areset_load", load_counter, 1);
    chk("areset_flash", flash, 1);
    chk("areset_lives", lives, 3);
    chk("areset_sm", start_machine, 0);
    chk("areset_go", game_over, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int r;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("rst_load", load_counter, 1);
    chk("rst_run", run, 0);
    chk("rst_flash", flash, 1);
    chk("rst_lives", lives, 3);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    start_pulse(5);
    chk("load_load", load_counter, 1);
    chk("load_run", run, 0);
    frame_tick(1'b0, 0);
    chk("play_run", run, 1);
    chk("play_sm", start_machine, 1);
    chk("play_load", load_counter, 0);
    pixels(3, 1'b0);
    frame_tick(1'b0, 0);
    chk("thresh3_lives", lives, 3);
    chk("thresh3_run", run, 1);
    pixels(4, 1'b0);
    frame_tick(1'b0, 0);
    chk("thresh4_lives", lives, 2);
    chk("thresh4_run", run, 0);
    chk("thresh4_flash", flash, 0);
    blink();
    pixels(3, 1'b0);
    frame_tick(1'b1, 0);
    chk("fe_pixel_lives", lives, 1);
    blink();
    pixels(4, 1'b0);
    frame_tick(1'b0, 0);
    chk("over_lives", lives, 0);
    chk("over_go", game_over, 1);
    chk("over_run", run, 0);
    chk("over_flash", flash, 1);
    pixels(10, 1'b0);
    frame_tick(1'b1, 0);
    chk("over_hold_lives", lives, 0);
    chk("over_hold_go", game_over, 1);
    start_pulse(5);
    chk("restart_lives", lives, 3);
    chk("restart_go", game_over, 0);
    chk("restart_load", load_counter, 1);
    frame_tick(1'b0, 0);
    pixels(300, 1'b0);
    frame_tick(1'b0, 0);
    chk("sat_one_hit", lives, 2);
    repeat (3) frame_tick(1'b0, 0);
    areset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    frame = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; frame = 1'b0;
    repeat (3) @(negedge clk);
    chk("fe_se_load", load_counter, 1);
    chk("fe_se_run", run, 0);
    frame_tick(1'b0, 0);
    chk("fe_se_play", run, 1);
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 19);
      if (r < 8) pixels($urandom_range(0, 8), 1'b1);
      else if (r < 16) frame_tick(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      else if (r < 19) start_pulse($urandom_range(1, 4));
      else if ($urandom_range(0, 9) == 0) areset();
      else repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
